pwm_duty_sequencer: RTL and testbench
=====================================

// Module: pwm_duty_sequencer
//
// PURPOSE
//   Controller that drives the CMPA duty register of the PWM generator.
//   - Accepts duty-change requests over a valid/ready handshake.
//   - Ramps CMPA toward the requested target by a programmable step, once per PWM period.
//   - Latches a fault input that forces the duty to zero.
//   Sits between the control plane (UART/register block) and the PWM generator.
//
// PARAMETERS
//   KPERIOD   14'd10416  max legal CMPA value; requested targets are clamped to it
//   CMP_W     14         width of the CMPA/duty datapath; must cover KPERIOD
//   STEP_W    8          width of the ramp step field
//
// PORTS
//   clk           in   1       system clock
//   rst           in   1       synchronous, active-high reset
//   period_tick   in   1       1-cycle strobe (clk domain) marking a PWM period boundary
//   req_valid     in   1       duty request valid
//   req_ready     out  1       sequencer can accept a request
//   req_duty      in   CMP_W   requested target duty (compare value)
//   req_step      in   STEP_W  ramp step per period; 0 is treated as 1
//   fault         in   1       level fault input; forces duty to 0
//   fault_clr     in   1       1-cycle clear of a latched fault
//   cmpa          out  CMP_W   registered duty value feeding PWM CMPA
//   busy          out  1       ramp in progress
//   at_target     out  1       cmpa equals the accepted target (IDLE/HOLD)
//   fault_active  out  1       fault latched
//   done_pulse    out  1       1-cycle pulse on the cycle cmpa first equals the target
//
// BEHAVIOUR
//   Reset values:
//     cmpa=0, target=0, step=1, state=IDLE, busy=0, at_target=1,
//     fault_active=0, done_pulse=0. req_ready=0 while rst is high.
//   States: IDLE, RAMP, HOLD, FAULT (registered state, decoded outputs).
//     busy = (RAMP)
//     at_target = (IDLE | HOLD)
//     fault_active = (FAULT)
//     req_ready = (IDLE | HOLD) & ~fault & ~rst
//   Accept: on req_valid & req_ready.
//     - Registers target = min(req_duty, KPERIOD) and step = max(req_step, 1).
//     - Next state is RAMP.
//     - A period_tick in the accept cycle is not used for stepping.
//     - If the clamped target equals cmpa, go straight to HOLD with done_pulse next cycle.
//   RAMP: cmpa changes only in the cycle after a period_tick, so it is stable within a period.
//     - diff = |target - cmpa|, computed at CMP_W+1 bits with no overflow or wrap.
//     - diff <= step: cmpa <= target, state -> HOLD, done_pulse=1 for that one cycle.
//     - otherwise: cmpa <= cmpa + step if target > cmpa, else cmpa - step.
//       cmpa never overshoots the target, never goes below 0 and never exceeds KPERIOD.
//     - Requests are not accepted in RAMP (req_ready=0); the requester holds valid.
//   HOLD: cmpa is held; a new request may be accepted (same rules as IDLE).
//   FAULT: fault=1 in any state means that on the next edge
//     - cmpa <= 0, state -> FAULT, and any pending ramp is discarded;
//     - no ramp is applied, even if period_tick is active in the same cycle.
//     Exit: only on fault_clr=1 with fault=0, to IDLE with cmpa=0 and target=0.
//     fault and fault_clr together: fault wins and the state stays FAULT.
//   Reset mid-ramp: returns all state to reset values; cmpa=0 on the next cycle.
//   Latency: request to first cmpa change is the first period_tick after accept, plus 1 cycle.
//
// TESTING
//   1. Reset, then req duty=100, step=30, 4 ticks -> cmpa 30,60,90,100; done_pulse with 100; HOLD.
//   2. From cmpa=100, req duty=10, step=50 -> cmpa 50, then 10; no underflow; at_target=1.
//   3. req duty=16000 (>KPERIOD), step=0 -> target clamps to 10416; cmpa steps +1 per tick.
//   4. Mid-ramp at cmpa=60: fault=1 -> next cycle cmpa=0, fault_active=1, req_ready=0;
//      fault_clr with fault=1 is ignored; fault_clr with fault=0 -> IDLE.
//   5. req_valid asserted during RAMP -> req_ready=0 until HOLD, then accepted; tick in accept cycle ignored.
//   6. rst asserted mid-ramp (cmpa=45) -> next cycle cmpa=0, busy=0, at_target=1, done_pulse=0.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty-ramp sequencer for the PWM CMPA register: accepts duty requests, ramps cmpa
// toward the target once per PWM period, and forces cmpa to zero on a latched fault.
module pwm_duty_sequencer #(
  parameter int                CMP_W   = 14,
  parameter int                STEP_W  = 8,
  parameter logic [CMP_W-1:0]  KPERIOD = 14'd10416
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_tick,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMP_W-1:0]  req_duty,
  input  logic [STEP_W-1:0] req_step,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [CMP_W-1:0]  cmpa,
  output logic              busy,
  output logic              at_target,
  output logic              fault_active,
  output logic              done_pulse
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            r_state;
  logic [CMP_W-1:0]  r_cmpa;
  logic [CMP_W-1:0]  r_target;
  logic [STEP_W-1:0] r_step;
  logic              r_done;

  logic              w_accept;
  logic [CMP_W-1:0]  w_req_target;
  logic [STEP_W-1:0] w_req_step;
  logic [CMP_W:0]    w_diff;
  logic [CMP_W:0]    w_step_ext;

  assign req_ready    = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !fault && !rst;
  assign w_accept     = req_valid && req_ready;
  assign w_req_target = (req_duty > KPERIOD) ? KPERIOD : req_duty;
  assign w_req_step   = (req_step == {STEP_W{1'b0}}) ? {{(STEP_W-1){1'b0}}, 1'b1} : req_step;

  // Distance is taken one bit wider so the subtraction can never wrap.
  assign w_diff     = (r_target > r_cmpa) ? ({1'b0, r_target} - {1'b0, r_cmpa})
                                          : ({1'b0, r_cmpa} - {1'b0, r_target});
  assign w_step_ext = (CMP_W+1)'(r_step);

  assign cmpa         = r_cmpa;
  assign done_pulse   = r_done;
  assign busy         = (r_state == S_RAMP);
  assign at_target    = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign fault_active = (r_state == S_FAULT);

  // Sequencer state, duty register and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cmpa   <= {CMP_W{1'b0}};
      r_target <= {CMP_W{1'b0}};
      r_step   <= {{(STEP_W-1){1'b0}}, 1'b1};
      r_done   <= 1'b0;
    end else if (fault) begin
      r_state <= S_FAULT;
      r_cmpa  <= {CMP_W{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            r_target <= w_req_target;
            r_step   <= w_req_step;
            if (w_req_target == r_cmpa) begin
              r_state <= S_HOLD;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RAMP;
            end
          end
        end
        S_RAMP: begin
          // Final step lands exactly on the target, so cmpa cannot overshoot.
          if (period_tick) begin
            if (w_diff <= w_step_ext) begin
              r_cmpa  <= r_target;
              r_state <= S_HOLD;
              r_done  <= 1'b1;
            end else if (r_target > r_cmpa) begin
              r_cmpa <= r_cmpa + CMP_W'(r_step);
            end else begin
              r_cmpa <= r_cmpa - CMP_W'(r_step);
            end
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            r_state  <= S_IDLE;
            r_cmpa   <= {CMP_W{1'b0}};
            r_target <= {CMP_W{1'b0}};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cmpa  <= {CMP_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: ramp up/down, clamping, fault latch,
// back-to-back requests and reset mid-ramp, with hand-computed expectations.
module tb_pwm_duty_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        period_tick;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_duty;
  logic [7:0]  req_step;
  logic        fault;
  logic        fault_clr;
  logic [13:0] cmpa;
  logic        busy;
  logic        at_target;
  logic        fault_active;
  logic        done_pulse;

  int checks   = 0;
  int failures = 0;

  pwm_duty_sequencer dut (
    .clk(clk), .rst(rst), .period_tick(period_tick),
    .req_valid(req_valid), .req_ready(req_ready), .req_duty(req_duty), .req_step(req_step),
    .fault(fault), .fault_clr(fault_clr), .cmpa(cmpa), .busy(busy),
    .at_target(at_target), .fault_active(fault_active), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    period_tick = 1'b1;
    step_clk();
    period_tick = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
  endtask

  task automatic accept_req(input logic [13:0] d, input logic [7:0] s);
    req_duty  = d;
    req_step  = s;
    req_valid = 1'b1;
    step_clk();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; period_tick = 1'b0; req_valid = 1'b0; req_duty = 14'd0;
    req_step = 8'd0; fault = 1'b0; fault_clr = 1'b0;
    step_clk();
    step_clk();
    checks++;
    if (cmpa !== 14'd0) begin
      failures++; $display("FAIL reset_cmpa got=%0d exp=0", cmpa);
    end
    checks++;
    if ({busy, at_target, fault_active, done_pulse, req_ready} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=01000", {busy, at_target, fault_active, done_pulse, req_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_ramp_up();
    int exp_c [4] = '{30, 60, 90, 100};
    accept_req(14'd100, 8'd30);
    checks++;
    if ({busy, cmpa} !== {1'b1, 14'd0}) begin
      failures++; $display("FAIL up_accept busy=%b cmpa=%0d exp busy=1 cmpa=0", busy, cmpa);
    end
    for (int i = 0; i < 4; i++) begin
      do_tick();
      checks++;
      if (cmpa !== 14'(exp_c[i]) || done_pulse !== (i == 3)) begin
        failures++;
        $display("FAIL up_tick%0d cmpa=%0d done=%b exp cmpa=%0d done=%b", i, cmpa, done_pulse, exp_c[i], (i == 3));
      end
      if (i < 3) begin
        step_clk();
        checks++;
        if (cmpa !== 14'(exp_c[i])) begin
          failures++; $display("FAIL up_stable%0d cmpa=%0d exp=%0d", i, cmpa, exp_c[i]);
        end
      end
    end
    checks++;
    if ({busy, at_target, fault_active} !== 3'b010) begin
      failures++; $display("FAIL up_hold flags=%b exp=010", {busy, at_target, fault_active});
    end
    step_clk();
    checks++;
    if (done_pulse !== 1'b0) begin
      failures++; $display("FAIL up_done_drop got=%b exp=0", done_pulse);
    end
  endtask

  task automatic test_ramp_down();
    accept_req(14'd10, 8'd50);
    do_tick();
    checks++;
    if (cmpa !== 14'd50 || done_pulse !== 1'b0) begin
      failures++; $display("FAIL down_1 cmpa=%0d done=%b exp cmpa=50 done=0", cmpa, done_pulse);
    end
    do_tick();
    checks++;
    if (cmpa !== 14'd10 || done_pulse !== 1'b1 || at_target !== 1'b1) begin
      failures++;
      $display("FAIL down_2 cmpa=%0d done=%b at=%b exp cmpa=10 done=1 at=1", cmpa, done_pulse, at_target);
    end
  endtask

  task automatic test_clamp_step0();
    step_clk();
    accept_req(14'd16000, 8'd0);
    do_tick();
    checks++;
    if (cmpa !== 14'd11) begin
      failures++; $display("FAIL step0_1 cmpa=%0d exp=11", cmpa);
    end
    do_tick();
    checks++;
    if (cmpa !== 14'd12 || busy !== 1'b1 || at_target !== 1'b0) begin
      failures++; $display("FAIL step0_2 cmpa=%0d busy=%b at=%b exp cmpa=12 busy=1 at=0", cmpa, busy, at_target);
    end
    apply_reset();
  endtask

  task automatic test_fault();
    accept_req(14'd100, 8'd30);
    do_tick();
    do_tick();
    checks++;
    if (cmpa !== 14'd60) begin
      failures++; $display("FAIL fault_pre cmpa=%0d exp=60", cmpa);
    end
    fault = 1'b1; period_tick = 1'b1;
    step_clk();
    period_tick = 1'b0;
    checks++;
    if (cmpa !== 14'd0 || {fault_active, req_ready, busy} !== 3'b100) begin
      failures++;
      $display("FAIL fault_enter cmpa=%0d fa/rdy/busy=%b exp cmpa=0 fa/rdy/busy=100", cmpa, {fault_active, req_ready, busy});
    end
    fault_clr = 1'b1;
    step_clk();
    checks++;
    if (fault_active !== 1'b1) begin
      failures++; $display("FAIL fault_clr_ignored fa=%b exp=1", fault_active);
    end
    fault = 1'b0;
    step_clk();
    fault_clr = 1'b0;
    checks++;
    if ({fault_active, at_target, req_ready} !== 3'b011 || cmpa !== 14'd0) begin
      failures++;
      $display("FAIL fault_exit fa/at/rdy=%b cmpa=%0d exp fa/at/rdy=011 cmpa=0", {fault_active, at_target, req_ready}, cmpa);
    end
    accept_req(14'd0, 8'd1);
    checks++;
    if (done_pulse !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL fault_target0 done=%b busy=%b exp done=1 busy=0", done_pulse, busy);
    end
  endtask

  task automatic test_clamp_full();
    step_clk();
    accept_req(14'd16000, 8'd255);
    for (int k = 1; k <= 40; k++) begin
      do_tick();
      checks++;
      if (cmpa !== 14'(255 * k)) begin
        failures++; $display("FAIL clamp_tick%0d cmpa=%0d exp=%0d", k, cmpa, 255 * k);
      end
    end
    do_tick();
    checks++;
    if (cmpa !== 14'd10416 || done_pulse !== 1'b1) begin
      failures++; $display("FAIL clamp_final cmpa=%0d done=%b exp cmpa=10416 done=1", cmpa, done_pulse);
    end
  endtask

  task automatic test_back_to_back();
    step_clk();
    accept_req(14'd10416, 8'd5);
    checks++;
    if ({done_pulse, busy, at_target} !== 3'b101) begin
      failures++; $display("FAIL b2b_equal done/busy/at=%b exp=101", {done_pulse, busy, at_target});
    end
    req_duty = 14'd10400; req_step = 8'd10; req_valid = 1'b1;
    step_clk();
    req_duty = 14'd10416; req_step = 8'd20;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_ramp_ready rdy=%b busy=%b exp rdy=0 busy=1", req_ready, busy);
    end
    do_tick();
    checks++;
    if (cmpa !== 14'd10406 || req_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_tick1 cmpa=%0d rdy=%b exp cmpa=10406 rdy=0", cmpa, req_ready);
    end
    do_tick();
    checks++;
    if (cmpa !== 14'd10400 || done_pulse !== 1'b1 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_tick2 cmpa=%0d done=%b rdy=%b exp cmpa=10400 done=1 rdy=1", cmpa, done_pulse, req_ready);
    end
    period_tick = 1'b1;
    step_clk();
    period_tick = 1'b0; req_valid = 1'b0;
    checks++;
    if (cmpa !== 14'd10400 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_accept_tick cmpa=%0d busy=%b exp cmpa=10400 busy=1", cmpa, busy);
    end
    do_tick();
    checks++;
    if (cmpa !== 14'd10416 || done_pulse !== 1'b1) begin
      failures++; $display("FAIL b2b_final cmpa=%0d done=%b exp cmpa=10416 done=1", cmpa, done_pulse);
    end
  endtask

  task automatic test_reset_mid_ramp();
    apply_reset();
    accept_req(14'd90, 8'd45);
    do_tick();
    checks++;
    if (cmpa !== 14'd45 || busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre cmpa=%0d busy=%b exp cmpa=45 busy=1", cmpa, busy);
    end
    rst = 1'b1; period_tick = 1'b1;
    step_clk();
    rst = 1'b0; period_tick = 1'b0;
    checks++;
    if (cmpa !== 14'd0 || {busy, at_target, done_pulse, fault_active} !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_post cmpa=%0d busy/at/done/fa=%b exp cmpa=0 busy/at/done/fa=0100",
               cmpa, {busy, at_target, done_pulse, fault_active});
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp_step0();
    test_fault();
    test_clamp_full();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
